// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC increment and fetch-stage state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Byte distance between consecutive instruction words.
    localparam word_t WBYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer keeping an instruction (and its PC+4) that arrived while
// IF/ID was stalled, so it can be delivered once the stall releases.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  clear,
    input  word_t instr_in,
    input  word_t pc_in,
    output word_t hold_instr,
    output word_t hold_pc,
    output logic  valid
);

    // Clear wins over load: a discarded entry must never be delivered.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            hold_instr <= '0;
            hold_pc    <= '0;
            valid      <= 1'b0;
        end else if (load) begin
            hold_instr <= instr_in;
            hold_pc    <= pc_in;
            valid      <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the icache read handshake and the
// IF/ID enable/flush controls. Optional performance counters are built when
// FETCH_PERF_EN is defined (fetch_count / bubble_count outputs).
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    output word_t instruction_out,
    output word_t pcout_out,
    output logic  ifid_enable,
    output logic  ifid_flush
`ifdef FETCH_PERF_EN
   ,output word_t fetch_count,
    output word_t bubble_count
`endif
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n, pc_plus4;
    logic         buf_load, buf_clear, buf_valid;
    word_t        hold_instr, hold_pc;

    assign pc_plus4 = pc + WBYTES;   // modulo 2^32, FFFFFFFC wraps to 0

    fetch_hold_buf u_hold_buf (
        .CLK        (CLK),
        .RST        (RST),
        .load       (buf_load),
        .clear      (buf_clear),
        .instr_in   (imemload),
        .pc_in      (pc_plus4),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc),
        .valid      (buf_valid)
    );

    // Next PC/state: redirect beats halt, halt beats the stall/ihit rules.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state)
            FETCH, HOLD: begin
                if (redirect) begin
                    pc_n      = redirect_pc;
                    state_n   = FETCH;
                    buf_clear = 1'b1;
                end else if (halt) begin
                    state_n = HALTED;
                end else if (state == FETCH) begin
                    if (ihit) begin
                        pc_n = pc_plus4;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_n  = HOLD;
                        end
                    end
                end else if (!stall) begin
                    state_n   = FETCH;
                    buf_clear = 1'b1;
                end
            end
            HALTED:  state_n = HALTED;
            default: state_n = FETCH;
        endcase
    end

    // PC and state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc    <= PC_INIT;
            state <= FETCH;
        end else begin
            pc    <= pc_n;
            state <= state_n;
        end
    end

    // Icache request and IF/ID controls; everything is forced low in reset.
    always_comb begin
        imemREN         = 1'b0;
        imemaddr        = '0;
        instruction_out = '0;
        pcout_out       = '0;
        ifid_enable     = 1'b0;
        ifid_flush      = 1'b0;
        if (!RST) begin
            imemaddr = pc;
            case (state)
                FETCH: begin
                    imemREN = 1'b1;
                    if (ihit) begin
                        if (!stall) begin
                            instruction_out = imemload;
                            pcout_out       = pc_plus4;
                            ifid_enable     = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_enable = 1'b1;
                        ifid_flush  = 1'b1;
                    end
                end
                HOLD: begin
                    instruction_out = buf_valid ? hold_instr : '0;
                    pcout_out       = buf_valid ? hold_pc : '0;
                    ifid_enable     = !stall;
                end
                default: ;
            endcase
            // Squash the wrong-path slot; any ihit data this cycle is dropped.
            if (redirect && state != HALTED) begin
                instruction_out = '0;
                pcout_out       = '0;
                ifid_enable     = 1'b1;
                ifid_flush      = 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters of delivered instructions and inserted bubbles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (ifid_enable && !ifid_flush) fetch_count <= sat_inc(fetch_count);
            if (ifid_flush) bubble_count <= sat_inc(bubble_count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a short mixed stretch,
// checked every cycle against a queue-based behavioural model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t PCI = 32'h40;

    logic  CLK = 1'b0;
    logic  RST = 1'b1, stall = 1'b0, redirect = 1'b0, halt = 1'b0, ihit = 1'b0;
    word_t redirect_pc = '0, imemload = '0;
    logic  imemREN, ifid_enable, ifid_flush;
    word_t imemaddr, instruction_out, pcout_out;
`ifdef FETCH_PERF_EN
    word_t fetch_count, bubble_count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    fetch_stage #(.PC_INIT(PCI)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .ihit            (ihit),
        .imemload        (imemload),
        .imemREN         (imemREN),
        .imemaddr        (imemaddr),
        .instruction_out (instruction_out),
        .pcout_out       (pcout_out),
        .ifid_enable     (ifid_enable),
        .ifid_flush      (ifid_flush)
`ifdef FETCH_PERF_EN
       ,.fetch_count     (fetch_count),
        .bubble_count    (bubble_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A fetched-but-undelivered instruction sits in a queue; "halted" is a
    // flag. Expected outputs are recomputed from those each cycle.
    word_t m_pc;
    bit    m_halted;
    word_t q_ins[$];
    word_t q_pc[$];
    word_t m_fc, m_bc;
    logic  e_ren, e_en, e_fl;
    word_t e_addr, e_ins, e_pco;

    function automatic void model_outputs();
        e_ren = 0; e_en = 0; e_fl = 0; e_addr = 0; e_ins = 0; e_pco = 0;
        if (RST) return;
        e_addr = m_pc;
        if (m_halted) return;
        if (q_ins.size() != 0) begin
            e_ins = q_ins[0];
            e_pco = q_pc[0];
            e_en  = !stall;
        end else begin
            e_ren = 1;
            e_en  = !stall;
            if (ihit && !stall) begin
                e_ins = imemload;
                e_pco = m_pc + 32'd4;
            end
            e_fl = !ihit && !stall;
        end
        if (redirect) begin
            e_en = 1; e_fl = 1; e_ins = 0; e_pco = 0;
        end
    endfunction

    function automatic void model_step();
        if (RST) begin
            m_fc = 0; m_bc = 0;
        end else begin
            if (e_en && !e_fl && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (e_fl && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        end
        if (RST) begin
            m_pc = PCI; m_halted = 0; q_ins.delete(); q_pc.delete();
        end else if (m_halted) begin
            // nothing moves until reset
        end else if (redirect) begin
            m_pc = redirect_pc; q_ins.delete(); q_pc.delete();
        end else if (halt) begin
            m_halted = 1;
        end else if (q_ins.size() != 0) begin
            if (!stall) begin q_ins.delete(); q_pc.delete(); end
        end else if (ihit) begin
            m_pc = m_pc + 32'd4;
            if (stall) begin q_ins.push_back(imemload); q_pc.push_back(m_pc); end
        end
    endfunction

    // Compare process: inputs change on negedge, outputs checked 3 time units
    // later, model advances on the rising edge together with the DUT.
    initial begin
        m_pc = PCI; m_halted = 0; m_fc = 0; m_bc = 0;
        forever begin
            @(negedge CLK);
            #3;
            model_outputs();
            chk("imemREN",         word_t'(imemREN),     word_t'(e_ren));
            chk("imemaddr",        imemaddr,             e_addr);
            chk("instruction_out", instruction_out,      e_ins);
            chk("pcout_out",       pcout_out,            e_pco);
            chk("ifid_enable",     word_t'(ifid_enable), word_t'(e_en));
            chk("ifid_flush",      word_t'(ifid_flush),  word_t'(e_fl));
`ifdef FETCH_PERF_EN
            chk("fetch_count",     fetch_count,          m_fc);
            chk("bubble_count",    bubble_count,         m_bc);
`endif
            @(posedge CLK);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic st, input logic rd, input word_t rp,
                         input logic h, input logic ih, input word_t im);
        @(negedge CLK);
        RST = r; stall = st; redirect = rd; redirect_pc = rp; halt = h; ihit = ih; imemload = im;
        #4;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string nm, input word_t act, input word_t mdl, input word_t want);
        chk(nm, act, want);
        chk({nm, "_model"}, mdl, want);
    endtask

    initial begin
        // reset
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h1234);
        lit("rst_ren",  word_t'(imemREN), word_t'(e_ren), 0);
        lit("rst_addr", imemaddr, e_addr, 0);
        lit("rst_en",   word_t'(ifid_enable), word_t'(e_en), 0);

        // streaming fetch from PC_INIT
        drive(0, 0, 0, 0, 0, 1, 32'h2001_0005);
        lit("s1_addr0", imemaddr, e_addr, 32'h40);
        lit("s1_pco0",  pcout_out, e_pco, 32'h44);
        lit("s1_ins0",  instruction_out, e_ins, 32'h2001_0005);
        drive(0, 0, 0, 0, 0, 1, 32'h2001_0005);
        lit("s1_addr1", imemaddr, e_addr, 32'h44);
        lit("s1_pco1",  pcout_out, e_pco, 32'h48);
        drive(0, 0, 0, 0, 0, 1, 32'h2001_0005);
        lit("s1_addr2", imemaddr, e_addr, 32'h48);
        lit("s1_pco2",  pcout_out, e_pco, 32'h4C);
        lit("s1_en2",   word_t'(ifid_enable), word_t'(e_en), 1);

        // icache misses produce bubbles, pc holds
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            lit("miss_flush", word_t'(ifid_flush), word_t'(e_fl), 1);
            lit("miss_addr",  imemaddr, e_addr, 32'h40);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h1111_1111);

        // ihit during stall -> HOLD, released later
        drive(0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        lit("hold_addr", imemaddr, e_addr, 32'h44);
        lit("hold_en0",  word_t'(ifid_enable), word_t'(e_en), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        lit("hold_ren1", word_t'(imemREN), word_t'(e_ren), 0);
        drive(0, 1, 0, 0, 0, 1, 32'h5555_5555);
        lit("hold_ren2", word_t'(imemREN), word_t'(e_ren), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        lit("rel_ins", instruction_out, e_ins, 32'hDEAD_BEEF);
        lit("rel_pco", pcout_out, e_pco, 32'h48);
        lit("rel_en",  word_t'(ifid_enable), word_t'(e_en), 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        lit("rel_next_addr", imemaddr, e_addr, 32'h48);

        // redirect while holding, with a simultaneous halt
        drive(0, 1, 0, 0, 0, 1, 32'hCAFE_F00D);
        drive(0, 1, 1, 32'h100, 1, 0, 0);
        lit("rd_flush", word_t'(ifid_flush), word_t'(e_fl), 1);
        lit("rd_en",    word_t'(ifid_enable), word_t'(e_en), 1);
        lit("rd_ins",   instruction_out, e_ins, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        lit("rd_addr", imemaddr, e_addr, 32'h100);
        lit("rd_ren",  word_t'(imemREN), word_t'(e_ren), 1);

        // halt is sticky and ignores redirects
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h7777_7777);
        lit("hlt_ren", word_t'(imemREN), word_t'(e_ren), 0);
        lit("hlt_en",  word_t'(ifid_enable), word_t'(e_en), 0);
        drive(0, 0, 1, 32'h200, 0, 0, 0);
        lit("hlt_rd_flush", word_t'(ifid_flush), word_t'(e_fl), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        lit("hlt_addr", imemaddr, e_addr, 32'h100);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        lit("hlt_rst_addr", imemaddr, e_addr, PCI);

        // PC wrap at top of address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h0C00_0000);
        lit("wrap_addr", imemaddr, e_addr, 32'hFFFF_FFFC);
        lit("wrap_pco",  pcout_out, e_pco, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        lit("wrap_next", imemaddr, e_addr, 32'h0);

        // mixed stretch, model-checked every cycle
        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), $urandom);
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and the icache request handshake (imemREN/ihit).
- Drives instruction_in, pcout_in, enable and flush of the IF/ID pipeline register.
- Holds a one-entry buffer so an instruction returned during a hazard stall is not lost; accepts redirects from branch/jump resolution and stops on halt.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- stall  input  1  hazard unit holds IF/ID this cycle.
- redirect  input  1  taken branch/jump/jr resolved downstream; squash wrong-path fetch.
- redirect_pc  input  32  target PC, valid when redirect=1.
- halt  input  1  halt decoded in ID; stop fetching.
- ihit  input  1  icache returned imemload this cycle.
- imemload  input  32  instruction word from icache.
- imemREN  output  1  icache read request.
- imemaddr  output  32  icache address (current PC).
- instruction_out  output  32  to IF/ID instruction_in.
- pcout_out  output  32  PC+4 of delivered instruction, to IF/ID pcout_in.
- ifid_enable  output  1  to IF/ID enable.
- ifid_flush  output  1  to IF/ID flush (insert bubble).

Behaviour:
- Reset (RST high at edge): pc<=PC_INIT, state<=FETCH, hold_instr<=0, hold_pc<=0. While RST is high, all outputs are 0.
- States:
  - FETCH: imemREN=1, imemaddr=pc.
  - HOLD: imemREN=0, the buffered instruction waits.
  - HALTED: imemREN=0, ifid_enable=0, ifid_flush=0. HALTED is sticky until RST.
- Priority each cycle: RST > redirect > halt > stall/ihit logic.
- Redirect, in FETCH or HOLD:
  - Registered: pc<=redirect_pc, state<=FETCH, hold buffer discarded.
  - Combinational this cycle: ifid_flush=1, ifid_enable=1; ihit data this cycle is ignored.
  - Ignored in HALTED.
- Halt (no redirect): state<=HALTED. The current-cycle IF/ID outputs follow the normal FETCH/HOLD rules; pc is frozen.
- FETCH, ihit=1, stall=0: instruction_out=imemload, pcout_out=pc+4, ifid_enable=1, ifid_flush=0; pc<=pc+4. Zero-latency pass-through.
- FETCH, ihit=1, stall=1: hold_instr<=imemload, hold_pc<=pc+4, pc<=pc+4, state<=HOLD; ifid_enable=0.
- FETCH, ihit=0, stall=0: ifid_enable=1, ifid_flush=1 (bubble); pc unchanged.
- FETCH, ihit=0, stall=1: ifid_enable=0, ifid_flush=0; pc unchanged.
- HOLD, stall=1: ifid_enable=0; outputs instruction_out=hold_instr, pcout_out=hold_pc.
- HOLD, stall=0: ifid_enable=1, instruction_out=hold_instr, pcout_out=hold_pc; state<=FETCH.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 0. redirect_pc is used verbatim (no alignment check).
- Outputs not driven by the rules above default to 0.
- imemaddr=pc in every state.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs fetch_count (32) and bubble_count (32), both reset to 0 and saturating at 32'hFFFFFFFF.
  - fetch_count increments on every cycle with ifid_enable=1 and ifid_flush=0.
  - bubble_count increments on every cycle with ifid_flush=1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gets:
  - fetch_state_t enum {FETCH, HOLD, HALTED}, 2 bits.
  - constant WBYTES=4 for the PC increment.
  - word_t, used for all 32-bit signals.
- One sub-module: fetch_hold_buf, the one-entry instruction/PC buffer with load, clear and valid.

Test Plan:
- Reset with PC_INIT=32'h40, then ihit=1 every cycle with imemload=32'h20010005, stall=0 -> imemaddr sequence 40,44,48; pcout_out sequence 44,48,4C; ifid_enable=1 every cycle.
- ihit=0 for 3 cycles with stall=0 -> ifid_flush=1 for those 3 cycles and pc holds 32'h40.
- At pc=32'h44: ihit=1 with imemload=32'hDEADBEEF and stall=1, stall held 2 more cycles, then released -> state HOLD, imemREN=0 during the stall; on release instruction_out=DEADBEEF, pcout_out=48, ifid_enable=1; next imemaddr=48.
- redirect=1 with redirect_pc=32'h100 while in HOLD, same cycle as halt=1 -> ifid_flush=1, hold buffer discarded, state not HALTED, next imemaddr=32'h100.
- halt=1 in FETCH -> from the next cycle imemREN=0 and ifid_enable=0 forever; a later redirect is ignored; RST returns pc to PC_INIT.
- pc=32'hFFFFFFFC with ihit=1 -> pcout_out=0 and next imemaddr=0. With FETCH_PERF_EN defined, fetch_count and bubble_count match the counts from the previous scenarios.
